// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port (WE3/A3/WD3).
// Define INIT_CLEAR_EN to sweep x1..x31 to zero after reset.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic             WE3,
   output logic [AW-1:0]    A3,
   output logic [DW-1:0]    WD3,
   output logic             init_done,
   output logic [3:0]       busy_cnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gidx;
   logic [PW-1:0]   nxt_ptr;
   logic [PW:0]     sum;
   logic [PW:0]     sum2;
   logic [PW-1:0]   cand;
   logic            found;
   logic            admit;
   logic [NREQ-1:0] gnt;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic [4:0]      rej_cnt;
   logic            we_n;
   logic [AW-1:0]   a_n;
   logic [DW-1:0]   wd_n;

`ifdef INIT_CLEAR_EN
   typedef enum logic {
      S_INIT,
      S_ARB
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [AW-1:0] idx;
   logic          done_q;

   // State register: reset always restarts the sweep
   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT;
      else     state <= state_n;
   end

   // Next state: leave INIT after the top register is cleared
   always_comb begin
      state_n = state;
      if (state == S_INIT && idx == {AW{1'b1}})
         state_n = S_ARB;
   end

   // Clear index and the sweep-finished flag
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= AW'(1);
         done_q <= 1'b0;
      end else begin
         if (state == S_INIT) idx <= idx + AW'(1);
         done_q <= (state_n == S_ARB);
      end
   end

   assign init_done = done_q;
   assign admit     = done_q & ~rst;
`else
   assign init_done = ~rst;
   assign admit     = ~rst;
`endif

   // Rotating priority scan starting at rr_ptr
   always_comb begin
      gnt   = '0;
      gidx  = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ))
            sum = sum - (PW+1)'(NREQ);
         cand = sum[PW-1:0];
         if (admit && !found && req_valid[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gidx      = cand;
         end
      end
   end

   // Grant mux, pointer advance and rejection count
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      rej_cnt  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
         end
         rej_cnt = rej_cnt + 5'(req_valid[i] & ~gnt[i]);
      end
      sum2 = {1'b0, gidx} + (PW+1)'(1);
      if (sum2 >= (PW+1)'(NREQ)) nxt_ptr = '0;
      else                       nxt_ptr = sum2[PW-1:0];
      if (rst)                 busy_cnt = 4'd0;
      else if (rej_cnt > 5'd15) busy_cnt = 4'hF;
      else                     busy_cnt = rej_cnt[3:0];
   end

   assign req_ready = gnt;

   // Next write-port values; x0 writes are consumed silently
   always_comb begin
      we_n = 1'b0;
      a_n  = A3;
      wd_n = WD3;
      if (|gnt && sel_addr != '0) begin
         we_n = 1'b1;
         a_n  = sel_addr;
         wd_n = sel_data;
      end
`ifdef INIT_CLEAR_EN
      if (state == S_INIT) begin
         we_n = 1'b1;
         a_n  = idx;
         wd_n = '0;
      end
`endif
   end

   // Registered write port and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         WE3    <= 1'b0;
         A3     <= '0;
         WD3    <= '0;
         rr_ptr <= '0;
      end else begin
         WE3 <= we_n;
         A3  <= a_n;
         WD3 <= wd_n;
         if (|gnt) rr_ptr <= nxt_ptr;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed steps plus random traffic
// checked against a round-robin reference model.
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            WE3;
   logic [AW-1:0]   A3;
   logic [DW-1:0]   WD3;
   logic            init_done;
   logic [3:0]      busy_cnt;

   regfile_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .WE3       (WE3),
      .A3        (A3),
      .WD3       (WD3),
      .init_done (init_done),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int          m_rr;
   bit          m_done;
   int          m_idx;
   bit          m_we;
   logic [4:0]  m_a;
   logic [31:0] m_wd;
   int          m_g;
   int          waitg [N];

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit v,
                          input logic [4:0] a,
                          input logic [31:0] d);
      req_valid[i]           = v;
      req_addr[i*AW +: AW]   = a;
      req_data[i*DW +: DW]   = d;
   endtask

   task automatic model_reset();
      m_rr   = 0;
      m_done = 0;
      m_idx  = 1;
      m_we   = 0;
      m_a    = '0;
      m_wd   = '0;
      for (int i = 0; i < N; i++) waitg[i] = 0;
   endtask

   // One clock: check combinational outputs, clock, check write port.
   task automatic cycle();
      int         g;
      int         eb;
      bit         adm;
      logic [N-1:0] er;
      #1;
`ifdef INIT_CLEAR_EN
      adm = m_done && !rst;
      chk("init_done", init_done, m_done);
`else
      adm = !rst;
      chk("init_done", init_done, !rst);
`endif
      g = -1;
      if (adm)
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_rr + k) % N])
               g = (m_rr + k) % N;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      eb = 0;
      if (!rst)
         for (int i = 0; i < N; i++)
            if (req_valid[i] && !er[i]) eb++;
      if (eb > 15) eb = 15;
      chk("req_ready", req_ready, er);
      chk("busy_cnt", busy_cnt, eb);
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i] || req_ready[i] || rst)
            waitg[i] = 0;
         else if (|req_ready)
            waitg[i]++;
      end
      for (int i = 0; i < N; i++)
         chk("wait_bound", waitg[i] <= N - 1, 1);
      m_g = g;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else if (adm) begin
         m_we = 0;
         if (g >= 0) begin
            m_rr = (g + 1) % N;
            if (req_addr[g*AW +: AW] != 0) begin
               m_we = 1;
               m_a  = req_addr[g*AW +: AW];
               m_wd = req_data[g*DW +: DW];
            end
         end
      end else begin
         m_we = 1;
         m_a  = 5'(m_idx);
         m_wd = '0;
         if (m_idx == 31) m_done = 1;
         m_idx++;
      end
      chk("WE3", WE3, m_we);
      chk("A3", A3, m_a);
      chk("WD3", WD3, m_wd);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      set_req(0, 1, 5'd5, 32'hA);
      set_req(1, 1, 5'd6, 32'hB);
      set_req(2, 1, 5'd7, 32'hC);
      @(posedge clk);
      #1;
      model_reset();
      chk("reset_WE3", WE3, 0);
      chk("reset_A3", A3, 0);
      chk("reset_WD3", WD3, 0);
      chk("reset_done", init_done, 0);
      cycle();
      rst = 1'b0;

`ifdef INIT_CLEAR_EN
      repeat (31) cycle();
      chk("sweep_done", init_done, 1);
      chk("sweep_last_A3", A3, 31);
`endif
      // all three valid: 001, 010, 100, 001
      #1;
      chk("rr_first", req_ready, 3'b001);
      repeat (4) cycle();
      chk("rr_last_A3", A3, 5);

      // only requester 2
      set_req(0, 0, 5'd0, 32'h0);
      set_req(1, 0, 5'd0, 32'h0);
      set_req(2, 1, 5'd10, 32'hDEADBEEF);
      #1;
      chk("only2_ready", req_ready, 3'b100);
      cycle();
      chk("only2_A3", A3, 10);
      chk("only2_WD3", WD3, 32'hDEADBEEF);
      set_req(0, 1, 5'd3, 32'h33);
      set_req(2, 1, 5'd11, 32'h44);
      #1;
      chk("ptr_wrap", req_ready, 3'b001);
      cycle();
      set_req(0, 0, 5'd0, 32'h0);

      // x0 write from requester 1, requester 2 waiting
      set_req(1, 1, 5'd0, 32'h1234);
      #1;
      chk("x0_ready", req_ready, 3'b010);
      cycle();
      chk("x0_WE3", WE3, 0);
      set_req(1, 0, 5'd0, 32'h0);
      cycle();
      chk("after_x0_A3", A3, 11);
      set_req(2, 0, 5'd0, 32'h0);
      cycle();

      // random traffic obeying the hold-until-ready rule
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if (m_g == i || !req_valid[i]) begin
               if ($urandom_range(0, 3) != 0)
                  set_req(i, 1,
                          5'($urandom_range(0, 31)),
                          $urandom);
               else
                  set_req(i, 0, 5'd0, 32'h0);
            end
         end
         cycle();
      end

      // reset during an ARB grant
      set_req(0, 1, 5'd20, 32'h55);
      set_req(1, 1, 5'd21, 32'h66);
      set_req(2, 1, 5'd22, 32'h77);
      rst = 1'b1;
      cycle();
      chk("rst_arb_WE3", WE3, 0);
      chk("rst_arb_done", init_done, 0);
      rst = 1'b0;

      // run, then reset again (mid-sweep at idx 12 when enabled)
      repeat (11) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
`ifdef INIT_CLEAR_EN
      chk("restart_A3", A3, 1);
`endif
      repeat (33) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
